// File: rtl/shift_exec_pipe_pkg.sv
// Shared definitions for the shift/rotate execution pipe.
// Contents: op encodings, size one-hot constants, flag bit positions and
// small datapath helpers (size masking, byte parity).
package shift_exec_pipe_pkg;

  typedef enum logic [2:0] {
    SHOP_SHL = 3'd0,
    SHOP_SHR = 3'd1,
    SHOP_SAR = 3'd2,
    SHOP_ROL = 3'd3,
    SHOP_ROR = 3'd4
  } shop_e;

  localparam logic [3:0] SZ32 = 4'b0100;
  localparam logic [3:0] SZ64 = 4'b1000;

  localparam int FL_CF = 0;
  localparam int FL_PF = 1;
  localparam int FL_AF = 2;
  localparam int FL_ZF = 3;
  localparam int FL_SF = 4;
  localparam int FL_OF = 5;

  // Keeps the low 32 bits for 32-bit ops, everything for 64-bit ops.
  function automatic logic [63:0] size_mask(input logic is64);
    return is64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  // Even parity: 1 when the byte holds an even number of ones.
  function automatic logic even_parity8(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/shift_exec_pipe_shlr.sv
// shlr: combinational shifter core.
// Ports:
//   val    operand (only the low 32 bits are used for 32-bit operation)
//   cnt    shift count
//   dir    0 = left, 1 = right
//   arith  right shifts fill with the operand sign bit
//   bit_en bit0 enables shifting at all, bit1 enables count bit 4,
//          bit2 enables count bit 5 and selects 64-bit operation,
//          bit3 is reserved for a wider count and also selects 64-bit
//   res    shifted value, zero-extended above the operand size
//   cout_l last bit shifted out of bit 7/15/31/63 on a left shift
//   cout_r last bit shifted out of bit 0 on a right shift
module shlr
  import shift_exec_pipe_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] val,
  input  logic [5:0]       cnt,
  input  logic             dir,
  input  logic             arith,
  input  logic [3:0]       bit_en,
  output logic [WIDTH-1:0] res,
  output logic [3:0]       cout_l,
  output logic             cout_r
);

  logic             is64_s;
  logic             cnt_nz_s;
  logic             fill_s;
  logic [5:0]       cnt_eff_s;
  logic [WIDTH-1:0] val_m_s;
  logic [WIDTH-1:0] val_x_s;
  logic [WIDTH-1:0] right_s;
  logic [WIDTH:0]   left_s;

  // Shift datapath: left shift keeps one extra bit to catch the carry out.
  always_comb begin
    is64_s    = bit_en[2] | bit_en[3];
    cnt_eff_s = {cnt[5] & is64_s, cnt[4] & bit_en[1], cnt[3:0]} & {6{bit_en[0]}};
    cnt_nz_s  = (cnt_eff_s != 6'd0);
    val_m_s   = val & size_mask(is64_s);
    fill_s    = arith & (is64_s ? val[63] : val[31]);
    if (is64_s) begin
      val_x_s = val;
    end else begin
      val_x_s = {{32{fill_s}}, val[31:0]};
    end
    // Sign fill is done by shifting the complement so ones enter at the top.
    if (fill_s) begin
      right_s = ~((~val_x_s) >> cnt_eff_s);
    end else begin
      right_s = val_x_s >> cnt_eff_s;
    end
    left_s = {1'b0, val_m_s} << cnt_eff_s;
    res    = (dir ? right_s : left_s[WIDTH-1:0]) & size_mask(is64_s);
    cout_r = cnt_nz_s & val_x_s[cnt_eff_s - 6'd1];
    if (cnt_nz_s) begin
      cout_l = {left_s[64], left_s[32], left_s[16], left_s[8]};
    end else begin
      cout_l = 4'b0000;
    end
  end

endmodule

// File: rtl/shift_exec_pipe.sv
// shift_exec_pipe: two-stage shift/rotate execution unit.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             kills both stages next edge
//   in_en/in_ready    issue handshake; in_op/in_sz/in_val0/in_val1/in_reg
//                     carry op, size one-hot, operand, raw count, dest tag
//   out_en/out_stall  writeback handshake
//   out_res           result, zero-extended for 32-bit ops
//   out_flags         {OF,SF,ZF,AF,PF,CF}
//   out_flags_wr      flags valid for writing (0 when masked count is 0)
//   out_reg           destination tag
module shift_exec_pipe
  import shift_exec_pipe_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int TAGW  = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_en,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [3:0]       in_sz,
  input  logic [WIDTH-1:0] in_val0,
  input  logic [5:0]       in_val1,
  input  logic [TAGW-1:0]  in_reg,
  output logic             out_en,
  input  logic             out_stall,
  output logic [WIDTH-1:0] out_res,
  output logic [5:0]       out_flags,
  output logic             out_flags_wr,
  output logic [TAGW-1:0]  out_reg
);

  logic             s1_vld_r;
  logic [2:0]       s1_op_r;
  logic             s1_is64_r;
  logic [WIDTH-1:0] s1_val_r;
  logic [5:0]       s1_cnt_r;
  logic [TAGW-1:0]  s1_reg_r;

  logic             s2_adv_s;
  logic             s1_adv_s;
  shop_e            op_dec_s;
  logic             pri_dir_s;
  logic             pri_arith_s;
  logic             is_rot_s;
  logic [3:0]       bit_en_s;
  logic [5:0]       rot_cnt_s;
  logic [WIDTH-1:0] pri_res_s;
  logic [WIDTH-1:0] rot_res_s;
  logic [3:0]       pri_cout_l_s;
  logic [3:0]       rot_cout_l_s;
  logic             pri_cout_r_s;
  logic             rot_cout_r_s;
  logic [WIDTH-1:0] res_s;
  logic             msb_s;
  logic             msb1_s;
  logic             cf_s;
  logic             of_s;
  logic [5:0]       flags_s;
  logic             flags_wr_s;
  logic             unused_s;

  assign s2_adv_s = ~out_en | ~out_stall;
  assign s1_adv_s = ~s1_vld_r | s2_adv_s;
  assign in_ready = s1_adv_s;
  assign unused_s = ^{in_sz[2:0], rot_cout_l_s, rot_cout_r_s, pri_cout_l_s[1:0]};

  // Stage 1 capture: op, size, operand, tag and the size-masked count.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      s1_vld_r  <= 1'b0;
      s1_op_r   <= 3'd0;
      s1_is64_r <= 1'b0;
      s1_val_r  <= '0;
      s1_cnt_r  <= 6'd0;
      s1_reg_r  <= '0;
    end else if (s1_adv_s) begin
      s1_vld_r <= in_en;
      if (in_en) begin
        s1_op_r   <= in_op;
        s1_is64_r <= in_sz[3];
        s1_val_r  <= in_val0;
        s1_cnt_r  <= in_sz[3] ? in_val1 : {1'b0, in_val1[4:0]};
        s1_reg_r  <= in_reg;
      end
    end
  end

  // Op decode; reserved encodings behave as SHL.
  always_comb begin
    op_dec_s    = SHOP_SHL;
    pri_dir_s   = 1'b0;
    pri_arith_s = 1'b0;
    is_rot_s    = 1'b0;
    case (s1_op_r)
      3'd1: begin op_dec_s = SHOP_SHR; pri_dir_s = 1'b1; end
      3'd2: begin op_dec_s = SHOP_SAR; pri_dir_s = 1'b1; pri_arith_s = 1'b1; end
      3'd3: begin op_dec_s = SHOP_ROL; is_rot_s = 1'b1; end
      3'd4: begin op_dec_s = SHOP_ROR; pri_dir_s = 1'b1; is_rot_s = 1'b1; end
      default: begin op_dec_s = SHOP_SHL; pri_dir_s = 1'b0; end
    endcase
    bit_en_s = s1_is64_r ? 4'b0111 : 4'b0011;
    // Complement count (W - cnt) mod W falls out of modular subtraction.
    if (s1_is64_r) begin
      rot_cnt_s = 6'd0 - s1_cnt_r;
    end else begin
      rot_cnt_s = {1'b0, 5'd0 - s1_cnt_r[4:0]};
    end
  end

  shlr #(.WIDTH(WIDTH)) u_shlr_pri (
    .val    (s1_val_r),
    .cnt    (s1_cnt_r),
    .dir    (pri_dir_s),
    .arith  (pri_arith_s),
    .bit_en (bit_en_s),
    .res    (pri_res_s),
    .cout_l (pri_cout_l_s),
    .cout_r (pri_cout_r_s)
  );

  // The complement shifter supplies the wrapped-around bits of a rotate.
  shlr #(.WIDTH(WIDTH)) u_shlr_rot (
    .val    (s1_val_r),
    .cnt    (rot_cnt_s),
    .dir    (~pri_dir_s),
    .arith  (1'b0),
    .bit_en (bit_en_s),
    .res    (rot_res_s),
    .cout_l (rot_cout_l_s),
    .cout_r (rot_cout_r_s)
  );

  // Result merge and flag derivation.
  always_comb begin
    if (is_rot_s) begin
      res_s = (pri_res_s | rot_res_s) & size_mask(s1_is64_r);
    end else begin
      res_s = pri_res_s;
    end
    msb_s  = s1_is64_r ? res_s[63] : res_s[31];
    msb1_s = s1_is64_r ? res_s[62] : res_s[30];
    case (op_dec_s)
      SHOP_SHR, SHOP_SAR: cf_s = pri_cout_r_s;
      SHOP_ROL:           cf_s = res_s[0];
      SHOP_ROR:           cf_s = msb_s;
      default:            cf_s = s1_is64_r ? pri_cout_l_s[3] : pri_cout_l_s[2];
    endcase
    if (s1_cnt_r == 6'd1) begin
      case (op_dec_s)
        SHOP_SHR: of_s = s1_is64_r ? s1_val_r[63] : s1_val_r[31];
        SHOP_SAR: of_s = 1'b0;
        SHOP_ROR: of_s = msb_s ^ msb1_s;
        default:  of_s = msb_s ^ cf_s;
      endcase
    end else begin
      of_s = 1'b0;
    end
    flags_s = 6'd0;
    if (s1_cnt_r != 6'd0) begin
      flags_s[FL_CF] = cf_s;
      flags_s[FL_PF] = even_parity8(res_s[7:0]);
      flags_s[FL_AF] = 1'b0;
      flags_s[FL_ZF] = (res_s == '0);
      flags_s[FL_SF] = msb_s;
      flags_s[FL_OF] = of_s;
      flags_wr_s     = 1'b1;
    end else begin
      flags_wr_s     = 1'b0;
    end
  end

  // Stage 2 output registers; they hold while a valid result is stalled.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_en       <= 1'b0;
      out_res      <= '0;
      out_flags    <= 6'd0;
      out_flags_wr <= 1'b0;
      out_reg      <= '0;
    end else if (s2_adv_s) begin
      out_en <= s1_vld_r;
      if (s1_vld_r) begin
        out_res      <= res_s;
        out_flags    <= flags_s;
        out_flags_wr <= flags_wr_s;
        out_reg      <= s1_reg_r;
      end
    end
  end

endmodule

// File: tb/tb_shift_exec_pipe.sv
module tb_shift_exec_pipe;
  import shift_exec_pipe_pkg::*;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_en;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [3:0]  in_sz;
  logic [63:0] in_val0;
  logic [5:0]  in_val1;
  logic [8:0]  in_reg;
  logic        out_en;
  logic        out_stall;
  logic [63:0] out_res;
  logic [5:0]  out_flags;
  logic        out_flags_wr;
  logic [8:0]  out_reg;

  shift_exec_pipe #(.WIDTH(64), .TAGW(9)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_en(in_en), .in_ready(in_ready),
    .in_op(in_op), .in_sz(in_sz), .in_val0(in_val0), .in_val1(in_val1),
    .in_reg(in_reg), .out_en(out_en), .out_stall(out_stall), .out_res(out_res),
    .out_flags(out_flags), .out_flags_wr(out_flags_wr), .out_reg(out_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    logic [5:0]  flags;
    logic        wr;
    logic [8:0]  tag;
    int          acc_cyc;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  sz;
    logic [63:0] v0;
    logic [5:0]  v1;
    logic [63:0] res;
    logic [5:0]  flags;
    logic        wr;
  } vec_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   consumed = 0;
  logic saw_not_ready;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: bit-by-bit shift/rotate by the architectural rules.
  function automatic exp_t model(input logic [2:0] op, input logic [3:0] sz,
                                 input logic [63:0] v0, input logic [5:0] v1,
                                 input logic [8:0] tag);
    exp_t e;
    int w, c, o, ones;
    logic [63:0] v, r;
    logic cf, of, msb, zf, pf;
    w = sz[3] ? 64 : 32;
    c = sz[3] ? int'(v1) : int'(v1 & 6'd31);
    v = sz[3] ? v0 : (v0 & 64'h0000_0000_FFFF_FFFF);
    o = (op > 3'd4) ? 0 : int'(op);
    r = 64'd0;
    cf = 1'b0;
    for (int i = 0; i < w; i++) begin
      case (o)
        0: if (i >= c) r[i] = v[i-c];
        1: if (i + c < w) r[i] = v[i+c];
        2: r[i] = (i + c < w) ? v[i+c] : v[w-1];
        3: r[(i+c)%w] = v[i];
        default: r[i] = v[(i+c)%w];
      endcase
    end
    case (o)
      0: if (c != 0) cf = v[w-c];
      1, 2: if (c != 0) cf = v[c-1];
      3: cf = r[0];
      default: cf = r[w-1];
    endcase
    msb = r[w-1];
    zf = (r == 64'd0);
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(r[i]);
    pf = ((ones % 2) == 0);
    of = 1'b0;
    if (c == 1) begin
      case (o)
        0, 3: of = msb ^ cf;
        1: of = v[w-1];
        2: of = 1'b0;
        default: of = r[w-1] ^ r[w-2];
      endcase
    end
    e.res = r;
    e.tag = tag;
    e.acc_cyc = 0;
    if (c == 0) begin
      e.flags = 6'd0;
      e.wr = 1'b0;
    end else begin
      e.flags = {of, msb, zf, 1'b0, pf, cf};
      e.wr = 1'b1;
    end
    return e;
  endfunction

  // One clock: drive at negedge, check handshake/outputs, update scoreboard.
  task automatic cycle(input logic en, input logic stall, input logic fl, input logic r,
                       input logic [2:0] op, input logic [3:0] sz, input logic [63:0] v0,
                       input logic [5:0] v1, input logic [8:0] tag, input exp_t e,
                       output logic acc);
    int n;
    logic exp_oe;
    exp_t h;
    in_en = en; out_stall = stall; flush = fl; rst = r;
    in_op = op; in_sz = sz; in_val0 = v0; in_val1 = v1; in_reg = tag;
    #1;
    n = sb.size();
    exp_oe = (n > 0) && ((cyc - sb[0].acc_cyc) >= 2);
    chk("in_ready", {63'd0, in_ready}, {63'd0, (n < 2) || !stall});
    chk("out_en", {63'd0, out_en}, {63'd0, exp_oe});
    if (!in_ready) saw_not_ready = 1'b1;
    if (out_en && !stall && n > 0) begin
      h = sb.pop_front();
      consumed++;
      chk("out_res", out_res, h.res);
      chk("out_flags", {58'd0, out_flags}, {58'd0, h.flags});
      chk("out_flags_wr", {63'd0, out_flags_wr}, {63'd0, h.wr});
      chk("out_reg", {55'd0, out_reg}, {55'd0, h.tag});
    end
    acc = en && in_ready && !fl && !r;
    if (fl || r) begin
      sb.delete();
    end else if (acc) begin
      h = e;
      h.acc_cyc = cyc;
      sb.push_back(h);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input logic stall);
    exp_t z;
    logic a;
    z = '{default: '0};
    cycle(1'b0, stall, 1'b0, 1'b0, 3'd0, SZ64, 64'd0, 6'd0, 9'd0, z, a);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tab[10];
    exp_t e;
    logic acc;
    int k, c0;
    logic [2:0]  rop;
    logic [3:0]  rsz;
    logic [63:0] rv0;
    logic [5:0]  rv1;
    logic [8:0]  rtag;

    tab[0] = '{3'd0, SZ64, 64'h8000_0000_0000_0001, 6'd1,  64'h2,                  6'b100001, 1'b1};
    tab[1] = '{3'd1, SZ32, 64'hFFFF_FFFF_8000_0000, 6'd31, 64'h1,                  6'b000000, 1'b1};
    tab[2] = '{3'd2, SZ32, 64'h0000_0000_8000_0000, 6'd36, 64'h0000_0000_F800_0000, 6'b010010, 1'b1};
    tab[3] = '{3'd3, SZ64, 64'h8000_0000_0000_0001, 6'd4,  64'h18,                 6'b000010, 1'b1};
    tab[4] = '{3'd4, SZ64, 64'h8000_0000_0000_0001, 6'd1,  64'hC000_0000_0000_0000, 6'b010011, 1'b1};
    tab[5] = '{3'd0, SZ64, 64'h55,                  6'd0,  64'h55,                 6'b000000, 1'b0};
    tab[6] = '{3'd0, SZ32, 64'h0000_0001_0000_0007, 6'd32, 64'h7,                  6'b000000, 1'b0};
    tab[7] = '{3'd7, SZ64, 64'h1,                   6'd63, 64'h8000_0000_0000_0000, 6'b010010, 1'b1};
    tab[8] = '{3'd1, SZ64, 64'h1,                   6'd2,  64'h0,                  6'b001010, 1'b1};
    tab[9] = '{3'd4, SZ32, 64'h1,                   6'd1,  64'h0000_0000_8000_0000, 6'b110011, 1'b1};

    rst = 1'b1; flush = 1'b0; in_en = 1'b0; out_stall = 1'b0;
    in_op = 3'd0; in_sz = SZ64; in_val0 = 64'd0; in_val1 = 6'd0; in_reg = 9'd0;
    saw_not_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_en", {63'd0, out_en}, 64'd0);
    chk("rst_out_res", out_res, 64'd0);
    chk("rst_out_flags", {58'd0, out_flags}, 64'd0);
    chk("rst_out_flags_wr", {63'd0, out_flags_wr}, 64'd0);
    chk("rst_out_reg", {55'd0, out_reg}, 64'd0);
    idle(1'b0);

    // Directed vectors with table-supplied expectations.
    for (int i = 0; i < 10; i++) begin
      e.res = tab[i].res; e.flags = tab[i].flags; e.wr = tab[i].wr;
      e.tag = 9'(i + 1); e.acc_cyc = 0;
      cycle(1'b1, 1'b0, 1'b0, 1'b0, tab[i].op, tab[i].sz, tab[i].v0, tab[i].v1, 9'(i + 1), e, acc);
      chk("tab_accept", {63'd0, acc}, 64'd1);
      repeat (3) idle(1'b0);
    end

    // Four back-to-back ops, stall for 3 cycles from the first result.
    saw_not_ready = 1'b0;
    k = 0;
    c0 = consumed;
    for (int t = 0; t < 14; t++) begin
      rv0 = {$urandom, $urandom};
      e = model(3'(k % 5), SZ64, rv0, 6'(k + 3), 9'(100 + k));
      cycle(k < 4, (t >= 2) && (t <= 4), 1'b0, 1'b0, 3'(k % 5), SZ64, rv0, 6'(k + 3),
            9'(100 + k), e, acc);
      if (acc) k++;
    end
    chk("seq_accepted", 64'(k), 64'd4);
    chk("seq_consumed", 64'(consumed - c0), 64'd4);
    chk("seq_ready_drop", {63'd0, saw_not_ready}, 64'd1);
    chk("seq_drained", 64'(sb.size()), 64'd0);

    // Flush with both stages full, stall held and a new op offered.
    for (int t = 0; t < 3; t++) begin
      e = model(3'd0, SZ64, 64'hF0, 6'd1, 9'd200);
      cycle(t < 2, 1'b1, 1'b0, 1'b0, 3'd0, SZ64, 64'hF0, 6'd1, 9'd200, e, acc);
    end
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, SZ64, 64'hF0, 6'd1, 9'd201, e, acc);
    chk("flush_out_en", {63'd0, out_en}, 64'd0);
    chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (3) idle(1'b0);

    // Reset while stalled with both stages full.
    for (int t = 0; t < 3; t++) begin
      e = model(3'd1, SZ32, 64'hFF, 6'd2, 9'd210);
      cycle(t < 2, 1'b1, 1'b0, 1'b0, 3'd1, SZ32, 64'hFF, 6'd2, 9'd210, e, acc);
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 3'd0, SZ64, 64'd0, 6'd0, 9'd0, e, acc);
    chk("rst_stall_out_en", {63'd0, out_en}, 64'd0);
    chk("rst_stall_out_res", out_res, 64'd0);
    idle(1'b0);

    // Randomized stream against the reference model.
    for (int t = 0; t < 500; t++) begin
      rop  = 3'($urandom_range(0, 7));
      rsz  = ($urandom % 2 == 0) ? SZ32 : SZ64;
      rv0  = {$urandom, $urandom};
      if ($urandom % 8 == 0) rv0 = 64'd0;
      rv1  = 6'($urandom);
      if ($urandom % 6 == 0) rv1 = 6'($urandom_range(0, 1));
      rtag = 9'($urandom);
      e = model(rop, rsz, rv0, rv1, rtag);
      cycle(($urandom % 10) < 7, ($urandom % 10) < 3, ($urandom % 60) == 0, 1'b0,
            rop, rsz, rv0, rv1, rtag, e, acc);
    end
    for (int t = 0; t < 6; t++) idle(1'b0);
    chk("final_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
